// File: rtl/mem_arb_pkg.sv
// Shared constants and tag type for the RAM read-port arbiter.
// Tag ids are sized for the largest supported requester count.
package mem_arb_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_RD_LAT  = 1;
  localparam int MAX_REQ     = 8;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);
  localparam int TAG_ID_W    = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with last-grant pointer register.
// Search begins one past the pointer; pointer moves only on adv.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            adv,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(N - 1);
    end else if (adv) begin
      ptr <= grant_id;
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one RAM read port among NUM_REQ requesters, returning tagged data.
// Define MEM_ARB_PRIO_EN to give requester 0 strict priority.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_LAT  = DEF_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data
);
  localparam int LID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] grant;
  logic [LID_W-1:0]   arb_id;
  logic [LID_W-1:0]   grant_id;
  logic               arb_adv;
  logic               fire;
  logic [ADDR_W-1:0]  addrs [NUM_REQ];
  tag_t               nxt_tag;
  tag_t               out_tag;
  tag_t [RD_LAT:0]    tags;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (LID_W)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (arb_req),
    .adv      (arb_adv),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

`ifdef MEM_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and never moves the pointer.
  assign arb_req = req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};
  assign arb_adv = fire & ~req_valid[0];

  always_comb begin
    if (req_valid[0]) begin
      grant    = NUM_REQ'(1);
      grant_id = '0;
    end else begin
      grant    = arb_grant;
      grant_id = arb_id;
    end
  end
`else
  assign arb_req  = req_valid;
  assign arb_adv  = fire;
  assign grant    = arb_grant;
  assign grant_id = arb_id;
`endif

  assign req_ready = grant;
  assign fire      = |grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addrs[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    nxt_tag       = '0;
    nxt_tag.valid = fire;
    nxt_tag.id    = TAG_ID_W'(grant_id);
  end

  assign out_tag = tags[RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      tags      <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (fire) begin
        mem_addr <= addrs[grant_id];
      end
      tags <= {tags[RD_LAT-1:0], nxt_tag};
      if (out_tag.valid) begin
        rsp_valid <= NUM_REQ'(1) << out_tag.id;
        rsp_data  <= mem_data;
      end else begin
        rsp_valid <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized and directed bench for mem_read_arbiter with a RAM model.
// Checks against a queue-based reference of grant order and read returns.
module tb_mem_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data = '0;

  always #5 clk = ~clk;

  mem_read_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  function automatic logic [63:0] ram_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // One-cycle registered RAM read port
  always @(posedge clk) mem_data <= ram_word(mem_addr);

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    int          id;
    logic [63:0] a;
  } slot_t;

  int          mptr;
  slot_t       pipe[$];
  logic [63:0] m_addr;
  logic [63:0] m_data;

  logic [N-1:0] o_ready, o_rv, e_ready, e_rv;
  logic [63:0]  o_addr, o_data, e_addr, e_data;

  task automatic model_reset();
    mptr = N - 1;
    pipe.delete();
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic int pick(input logic [N-1:0] v);
`ifdef MEM_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    int    g;
    slot_t s;
    g = pick(v);
    e_ready = '0;
    s.v = 1'b0;
    s.id = 0;
    s.a = '0;
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      s.v = 1'b1;
      s.id = g;
      s.a = a[g*AW +: AW];
      m_addr = s.a;
`ifdef MEM_ARB_PRIO_EN
      if (g != 0) mptr = g;
`else
      mptr = g;
`endif
    end
    pipe.push_back(s);
    e_rv = '0;
    if (pipe.size() > 2) begin
      s = pipe.pop_front();
      if (s.v) begin
        e_rv[s.id] = 1'b1;
        m_data = ram_word(s.a);
      end
    end
    e_addr = m_addr;
    e_data = m_data;
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    @(negedge clk);
    req_valid = v;
    req_addr = a;
    #1;
    o_ready = req_ready;
    @(posedge clk);
    #1;
    o_rv = rsp_valid;
    o_addr = mem_addr;
    o_data = rsp_data;
    model_step(v, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = {$urandom, $urandom};
    return a;
  endfunction

  task automatic test_reset();
    #3;
    rst = 1'b1;
    #1;
    checks += 4;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid);
    end
    if (rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_rsp_data got %h exp 0", rsp_data);
    end
    if (mem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem_addr got %h exp 0", mem_addr);
    end
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ready got %b exp 0000", req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    a = '0;
    a[2*AW +: AW] = 64'h100;
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 4'b0100 : 4'b0000, a);
      checks += 4;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL single_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_addr !== e_addr) begin
        errors++;
        $display("FAIL single_addr c%0d got %h exp %h", i, o_addr, e_addr);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL single_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_data !== e_data) begin
        errors++;
        $display("FAIL single_data c%0d got %h exp %h", i, o_data, e_data);
      end
      if (i == 0) begin
        checks += 2;
        if (o_ready !== 4'b0100) begin
          errors++;
          $display("FAIL single_grant got %b exp 0100", o_ready);
        end
        if (o_addr !== 64'h100) begin
          errors++;
          $display("FAIL single_memaddr got %h exp 100", o_addr);
        end
      end
      if (i == 2) begin
        checks += 2;
        if (o_rv !== 4'b0100) begin
          errors++;
          $display("FAIL single_strobe got %b exp 0100", o_rv);
        end
        if (o_data !== ram_word(64'h100)) begin
          errors++;
          $display("FAIL single_word got %h exp %h", o_data, ram_word(64'h100));
        end
      end
    end
  endtask

  task automatic test_all_rotate();
    logic [N*AW-1:0] a;
    a = rand_addrs();
    for (int i = 0; i < 10; i++) begin
      step((i < 8) ? 4'b1111 : 4'b0000, a);
      checks += 4;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL rotate_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_addr !== e_addr) begin
        errors++;
        $display("FAIL rotate_addr c%0d got %h exp %h", i, o_addr, e_addr);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL rotate_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_data !== e_data) begin
        errors++;
        $display("FAIL rotate_data c%0d got %h exp %h", i, o_data, e_data);
      end
    end
  endtask

  task automatic test_pair();
    logic [N*AW-1:0] a;
    logic [N-1:0]    v;
    logic [N-1:0]    lit [4];
    do_reset();
    lit = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    a = rand_addrs();
    for (int i = 0; i < 7; i++) begin
      v = (i == 0) ? 4'b0010 : (i < 5) ? 4'b1010 : 4'b0000;
      step(v, a);
      checks += 4;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL pair_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_addr !== e_addr) begin
        errors++;
        $display("FAIL pair_addr c%0d got %h exp %h", i, o_addr, e_addr);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL pair_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_data !== e_data) begin
        errors++;
        $display("FAIL pair_data c%0d got %h exp %h", i, o_data, e_data);
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (o_ready !== lit[i-1]) begin
          errors++;
          $display("FAIL pair_order c%0d got %b exp %b", i, o_ready, lit[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [N*AW-1:0] a;
    do_reset();
    a = rand_addrs();
    step(4'b0011, a);
    step(4'b0011, a);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_assert got %b exp 0000", rsp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_first got %b exp 0000", rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_second got %b exp 0000", rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step((i == 0) ? 4'b1111 : 4'b0000, a);
      checks += 2;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL midrst_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL midrst_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (i == 0) begin
        checks++;
        if (o_ready !== 4'b0001) begin
          errors++;
          $display("FAIL midrst_first_grant got %b exp 0001", o_ready);
        end
      end
    end
  endtask

  task automatic test_prio();
    logic [N*AW-1:0] a;
    int              lit [9];
`ifdef MEM_ARB_PRIO_EN
    lit = '{0, 0, 0, 0, 0, 1, 2, 1, 2};
`else
    lit = '{0, 1, 2, 0, 1, 2, 1, 2, 1};
`endif
    do_reset();
    a = rand_addrs();
    for (int i = 0; i < 11; i++) begin
      step((i < 5) ? 4'b0111 : (i < 9) ? 4'b0110 : 4'b0000, a);
      checks += 4;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL prio_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_addr !== e_addr) begin
        errors++;
        $display("FAIL prio_addr c%0d got %h exp %h", i, o_addr, e_addr);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL prio_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_data !== e_data) begin
        errors++;
        $display("FAIL prio_data c%0d got %h exp %h", i, o_data, e_data);
      end
      if (i < 9) begin
        checks++;
        if (o_ready !== (4'b0001 << lit[i])) begin
          errors++;
          $display("FAIL prio_order c%0d got %b exp grant %0d", i, o_ready, lit[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N*AW-1:0] a;
    logic [N-1:0]    v;
    for (int i = 0; i < 200; i++) begin
      a = rand_addrs();
      v = N'($urandom_range(0, 15));
      step(v, a);
      checks += 4;
      if (o_ready !== e_ready) begin
        errors++;
        $display("FAIL rand_ready c%0d got %b exp %b", i, o_ready, e_ready);
      end
      if (o_addr !== e_addr) begin
        errors++;
        $display("FAIL rand_addr c%0d got %h exp %h", i, o_addr, e_addr);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL rand_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_data !== e_data) begin
        errors++;
        $display("FAIL rand_data c%0d got %h exp %h", i, o_data, e_data);
      end
    end
  endtask

  task automatic test_idle();
    logic [63:0] last;
    last = e_addr;
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, rand_addrs());
      checks += 3;
      if (o_addr !== last) begin
        errors++;
        $display("FAIL idle_addr c%0d got %h exp %h", i, o_addr, last);
      end
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL idle_rv c%0d got %b exp %b", i, o_rv, e_rv);
      end
      if (o_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_ready c%0d got %b exp 0000", i, o_ready);
      end
      if (i >= 2) begin
        checks++;
        if (o_rv !== 4'b0000) begin
          errors++;
          $display("FAIL idle_quiet c%0d got %b exp 0000", i, o_rv);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_rotate();
    test_pair();
    test_reset_midflight();
    test_prio();
    test_random();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Round-robin arbiter sharing the single DPI-backed RAM read port (64-bit address in, 64-bit registered data out, one-cycle read latency) among NUM_REQ requesters, e.g. coefficient loaders and NTT stages of the FHE core. It accepts at most one read per cycle via valid/ready, drives the RAM address register, tracks in-flight reads in a latency-matched tag pipeline, and returns each result on a broadcast data bus with a one-hot response strobe. It sits between the compute units and the RAM model / future memory controller.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 64: address width, passed to RAM unchanged
- DATA_W, 64: data width
- RD_LAT, 1: RAM read latency in cycles (address sampled at edge, data registered)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready at posedge
- rsp_valid  out  NUM_REQ  one-hot strobe, one cycle per returned read
- rsp_data  out  DATA_W  read data, meaningful only while any rsp_valid bit is high
- mem_addr  out  ADDR_W  registered address to RAM read port
- mem_data  in  DATA_W  RAM read data

## Operation
- Arbitration combinational: req_ready[i] high for exactly one i among asserted req_valid, none if no request; req_ready may depend on req_valid.
- Round-robin pointer holds last granted index; search starts at pointer+1 modulo NUM_REQ; pointer updates only on a handshake.
- On handshake: mem_addr <= req_addr[grant]; tag {valid=1, id=grant} enters pipeline stage 0. No handshake: mem_addr holds, tag valid=0.
- Tag pipeline depth RD_LAT+1; at output stage, rsp_data <= mem_data and rsp_valid <= onehot(id) if tag valid, else rsp_valid <= 0, rsp_data holds.
- No response backpressure: requesters must sink every rsp_valid pulse. Responses return in grant order.
- Sustained throughput one read per cycle; single requester with continuous valid gets every cycle.
- Requester may drop req_valid without handshake; no state is kept for it.

## Timing
- Reset values: req_ready follows comb logic (0 with no valid), rsp_valid 0, rsp_data 0, mem_addr 0, pointer NUM_REQ-1 (so requester 0 wins first), all tags invalid.
- Latency: handshake at edge E0 -> mem_addr valid after E0 -> RAM data after E1 -> rsp_valid/rsp_data high in cycle after E(RD_LAT+1); 2 cycles for RD_LAT=1.
- Reset asserted mid-operation: in-flight tags dropped, no response delivered for them; rsp_valid low from reset assertion.
- Pointer wrap: after NUM_REQ-1 granted, search starts at 0.
- Simultaneous requests all high: grants rotate 0,1,..,NUM_REQ-1,0 one per cycle.

## Configuration
- MEM_ARB_PRIO_EN defined: requester 0 has strict priority—granted whenever req_valid[0], pointer not updated by its grants; others round-robin among themselves when req_valid[0] low.
- Undefined: pure round-robin across all requesters as above.

## Structure
- Package mem_arb_pkg: default NUM_REQ/ADDR_W/DATA_W/RD_LAT constants, ID_W = clog2(NUM_REQ), tag struct {valid, id}.
- Sub-module rr_arbiter: combinational one-hot grant from request vector and pointer, plus pointer register with async reset; reused by later write-port arbiter.

## Test plan
- Single requester 2, valid with addr 0x100 for one cycle -> req_ready[2] in same cycle, mem_addr=0x100 next cycle, rsp_valid=4'b0100 with RAM word at 0x100 two cycles after handshake.
- All four valid continuously, distinct addrs -> grants 0,1,2,3,0,1 on consecutive cycles; responses same order, one per cycle, data matches each addr.
- Requesters 1 and 3 valid, pointer at 1 -> grant 3 then 1; requester 0 and 2 never ready.
- Reset pulse one cycle after two back-to-back handshakes -> no rsp_valid for either; after reset first grant goes to requester 0.
- With MEM_ARB_PRIO_EN, requester 0 valid 5 cycles alongside 1 and 2 -> 0 granted all 5, then 1, 2 alternate; without macro -> 0,1,2 rotate.
- Idle bus 10 cycles after traffic -> rsp_valid stays 0, mem_addr holds last address.
